sw_button_ctrl: RTL and testbench
=================================

# sw_button_ctrl

Front-end conditioner for the stopwatch. Takes four raw, asynchronous, bouncing push-buttons and produces the stopwatch control signals: `g` (run), `c` (clear), `u` (count up/down) and `p` (display hold). The outputs are sized and timed to connect directly to the stopwatch counter's `g`, `c`, `u` and `p` inputs. Each button is synchronized, debounced and edge-detected; its press event then toggles or pulses the corresponding control.

## Interface
- `DB_TICKS`, default 2_000_000: number of consecutive stable cycles needed to accept a level change (20 ms at 100 MHz). Must be ≥2. Benches use 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `btn_go`  in  1  raw run/stop button, asynchronous, active-high.
- `btn_clr`  in  1  raw clear button, asynchronous, active-high.
- `btn_up`  in  1  raw direction button, asynchronous, active-high.
- `btn_lap`  in  1  raw lap/hold button, asynchronous, active-high.
- `g`  out  1  run level; 1 means the counter advances.
- `c`  out  1  clear, a one-cycle pulse.
- `u`  out  1  direction level; 1 = up, 0 = down.
- `p`  out  1  hold level; 1 freezes the displayed value while counting continues.

## Operation
- **Synchronizer.** Each button passes through a 2-flop synchronizer with no reset dependence on the data path. Synchronizer flops are cleared to 0 on reset.
- **Debounce FSM, one per button.** States: ZERO, WAIT1, ONE, WAIT0. Counter width is clog2(DB_TICKS).
  - ZERO: a synced input of 1 moves to WAIT1 and loads counter = 0.
  - WAIT1: input 0 returns to ZERO (bounce rejected). Input 1 increments the counter. When counter reaches DB_TICKS-1 with input still 1, move to ONE and emit a one-cycle `press` event.
  - ONE: input 0 moves to WAIT0 and loads counter = 0.
  - WAIT0: input 1 returns to ONE. When counter reaches DB_TICKS-1 with input still 0, move to ZERO. No event is emitted on release.
  - Holding a button produces exactly one event. Auto-repeat is not provided.
- **Control register**, updated on press events:
  - go press: `g` <= ~`g`.
  - up press: `u` <= ~`u`.
  - lap press: `p` <= ~`p`.
  - clr press: `c` <= 1 for one cycle, `g` <= 0 and `p` <= 0. `u` is unchanged.
- **Simultaneous events in the same cycle:**
  - clr overrides go and lap: `g` = 0 and `p` = 0 regardless of other presses.
  - An up press alongside clr still toggles `u`.
  - Go and lap pressed together both toggle.
- **Reset values:** `g`=0, `c`=0, `u`=1, `p`=0. All FSMs are in ZERO with counters at 0.
- **Reset mid-operation.** Asserting `reset_n`=0 in any state restores the reset values on the next edge. A button still held when reset deasserts is treated as a new press: it passes through WAIT1 and yields one event after the full debounce interval.

## Timing
- Let the raw button rise just before edge 0 and stay stable.
- The synchronized level is 1 at edge 2, and the FSM enters WAIT1 at edge 2.
- The press event fires at edge 2+DB_TICKS.
- The control outputs change after edge 3+DB_TICKS. `c` is high for exactly that one cycle.
- A bounce shorter than DB_TICKS synced cycles produces no event, as does any glitch of 1 cycle or less.
- Minimum spacing between two accepted presses of the same button is 2·DB_TICKS+2 cycles, covering press, release and press again.
- All outputs come directly from flops and have no combinational path from any input.

## Structure
- **Package `sw_ctrl_pkg`:**
  - debounce state enum: ZERO, WAIT1, ONE, WAIT0
  - reset-value constants: `G_RST`=0, `U_RST`=1, `P_RST`=0
  - a default constant `DB_TICKS_DEF`
- **Sub-module `db_fsm`:** contains the synchronizer, debounce FSM and press-event output, parameterized by DB_TICKS. It is instantiated four times.
- **Top `sw_button_ctrl`:** contains only the instances plus the control register and the priority logic.

## Test plan
All scenarios use DB_TICKS=4.
1. **Reset.** Hold `reset_n`=0 for 3 cycles with all buttons at 0 → `g`=0, `c`=0, `u`=1, `p`=0. Outputs are stable for 20 cycles after release.
2. **Clean press.** Raise `btn_go` at cycle 10 and hold it for 30 cycles → `g` becomes 1 after edge 17 and stays 1 through release. Press again after release → `g` returns to 0 after a further 7 cycles from the new rise.
3. **Bounce rejection.** `btn_up` toggles 1,0,1,0,1 at 2-cycle intervals, then holds at 1 → exactly one toggle (`u`: 1→0). It occurs 7 cycles after the final rise.
4. **Clear priority.** With `g`=1 and `p`=1, raise `btn_clr` and `btn_go` in the same cycle → `c` is high for one cycle, `g`=0, `p`=0, and `u` is unchanged.
5. **Simultaneous up+clr.** With `u`=1, press both in the same cycle → `c` pulses once and `u`=0.
6. **Reset mid-debounce.** Assert `reset_n`=0 while `btn_lap` is held in WAIT1 and keep the button held through reset → `p` stays 0 during reset. `p` becomes 1 exactly 7 cycles after reset deasserts.

Source files
------------

// File: rtl/sw_ctrl_pkg.sv
// Shared types and constants for the stopwatch button front-end.
package sw_ctrl_pkg;

    typedef enum logic [1:0] {
        ZERO,
        WAIT1,
        ONE,
        WAIT0
    } db_state_e;

    localparam logic G_RST = 1'b0;
    localparam logic U_RST = 1'b1;
    localparam logic P_RST = 1'b0;

    localparam int DB_TICKS_DEF = 2_000_000;

endpackage

// File: rtl/db_fsm.sv
// One button channel: 2-flop synchronizer, debounce FSM and one-cycle press event.
module db_fsm
    import sw_ctrl_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic             btn_s;
    db_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             press_q;

    always_comb begin
        sync_d = {sync_q[0], btn_i};
    end

    assign btn_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Press fires only on the ZERO->ONE path; release is silent.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ZERO;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                ZERO: begin
                    if (btn_s) begin
                        state_q <= WAIT1;
                        cnt_q   <= '0;
                    end
                end
                WAIT1: begin
                    if (!btn_s) begin
                        state_q <= ZERO;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ONE;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ONE: begin
                    if (!btn_s) begin
                        state_q <= WAIT0;
                        cnt_q   <= '0;
                    end
                end
                WAIT0: begin
                    if (btn_s) begin
                        state_q <= ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ZERO;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ZERO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/sw_button_ctrl.sv
// Stopwatch button front-end: four debounced buttons driving the g/c/u/p control register.
module sw_button_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_go,
    input  logic btn_clr,
    input  logic btn_up,
    input  logic btn_lap,
    output logic g,
    output logic c,
    output logic u,
    output logic p
);

    logic go_ev, clr_ev, up_ev, lap_ev;
    logic g_q, c_q, u_q, p_q;
    logic g_d, c_d, u_d, p_d;

    db_fsm #(.DB_TICKS(DB_TICKS)) u_db_go  (.clk(clk), .reset_n(reset_n), .btn_i(btn_go),  .press_o(go_ev));
    db_fsm #(.DB_TICKS(DB_TICKS)) u_db_clr (.clk(clk), .reset_n(reset_n), .btn_i(btn_clr), .press_o(clr_ev));
    db_fsm #(.DB_TICKS(DB_TICKS)) u_db_up  (.clk(clk), .reset_n(reset_n), .btn_i(btn_up),  .press_o(up_ev));
    db_fsm #(.DB_TICKS(DB_TICKS)) u_db_lap (.clk(clk), .reset_n(reset_n), .btn_i(btn_lap), .press_o(lap_ev));

    // Clear wins over go/lap in the same cycle; direction is never cleared.
    always_comb begin
        g_d = g_q;
        c_d = 1'b0;
        u_d = u_q;
        p_d = p_q;
        if (go_ev)  g_d = ~g_q;
        if (up_ev)  u_d = ~u_q;
        if (lap_ev) p_d = ~p_q;
        if (clr_ev) begin
            c_d = 1'b1;
            g_d = 1'b0;
            p_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            g_q <= G_RST;
            c_q <= 1'b0;
            u_q <= U_RST;
            p_q <= P_RST;
        end else begin
            g_q <= g_d;
            c_q <= c_d;
            u_q <= u_d;
            p_q <= p_d;
        end
    end

    assign g = g_q;
    assign c = c_q;
    assign u = u_q;
    assign p = p_q;

endmodule

// File: tb/tb_sw_button_ctrl.sv
// Directed self-checking bench for sw_button_ctrl with DB_TICKS=4.
module tb_sw_button_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    logic btn_go, btn_clr, btn_up, btn_lap;
    logic g, c, u, p;

    int checks = 0;
    int errors = 0;

    sw_button_ctrl #(.DB_TICKS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_go  (btn_go),
        .btn_clr (btn_clr),
        .btn_up  (btn_up),
        .btn_lap (btn_lap),
        .g       (g),
        .c       (c),
        .u       (u),
        .p       (p)
    );

    always #5 clk = ~clk;

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eg, input logic ec, input logic eu, input logic ep);
        chk({tag, ".g"}, g, eg);
        chk({tag, ".c"}, c, ec);
        chk({tag, ".u"}, u, eu);
        chk({tag, ".p"}, p, ep);
    endtask

    initial begin
        // Inputs change and outputs are sampled on the falling edge.
        reset_n = 1'b0;
        btn_go  = 1'b0;
        btn_clr = 1'b0;
        btn_up  = 1'b0;
        btn_lap = 1'b0;

        // 1. Reset
        wait_neg(3);
        chk_all("reset", 1'b0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_neg(1);
            chk_all("idle", 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // 2. Clean press of go, held 30 cycles, then a second press
        btn_go = 1'b1;
        wait_neg(7);
        chk("go_before", g, 1'b0);
        wait_neg(1);
        chk_all("go_after", 1'b1, 1'b0, 1'b1, 1'b0);
        wait_neg(22);
        chk("go_held", g, 1'b1);
        btn_go = 1'b0;
        wait_neg(15);
        chk("go_released", g, 1'b1);
        btn_go = 1'b1;
        wait_neg(7);
        chk("go2_before", g, 1'b1);
        wait_neg(1);
        chk("go2_after", g, 1'b0);
        wait_neg(5);
        btn_go = 1'b0;
        wait_neg(15);
        chk_all("go2_settled", 1'b0, 1'b0, 1'b1, 1'b0);

        // 3. Bounce on up: 1,0,1,0 for 2 cycles each, then hold 1
        for (int i = 0; i < 4; i++) begin
            btn_up = (i % 2 == 0);
            wait_neg(2);
            chk("bounce_u", u, 1'b1);
        end
        btn_up = 1'b1;
        wait_neg(7);
        chk("bounce_before", u, 1'b1);
        wait_neg(1);
        chk("bounce_after", u, 1'b0);
        wait_neg(10);
        chk("bounce_held", u, 1'b0);
        btn_up = 1'b0;
        wait_neg(15);
        chk_all("bounce_settled", 1'b0, 1'b0, 1'b0, 1'b0);

        // Go and lap together both toggle
        btn_go  = 1'b1;
        btn_lap = 1'b1;
        wait_neg(8);
        chk_all("go_lap", 1'b1, 1'b0, 1'b0, 1'b1);
        btn_go  = 1'b0;
        btn_lap = 1'b0;
        wait_neg(15);

        // 4. Clear priority over go with g=1, p=1
        btn_clr = 1'b1;
        btn_go  = 1'b1;
        wait_neg(7);
        chk_all("clr_before", 1'b1, 1'b0, 1'b0, 1'b1);
        wait_neg(1);
        chk_all("clr_pulse", 1'b0, 1'b1, 1'b0, 1'b0);
        wait_neg(1);
        chk_all("clr_done", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_clr = 1'b0;
        btn_go  = 1'b0;
        wait_neg(15);

        // Clear overrides go and lap toggles from g=0, p=0
        btn_clr = 1'b1;
        btn_go  = 1'b1;
        btn_lap = 1'b1;
        wait_neg(8);
        chk_all("clr_go_lap", 1'b0, 1'b1, 1'b0, 1'b0);
        wait_neg(1);
        chk("clr_go_lap_c", c, 1'b0);
        btn_clr = 1'b0;
        btn_go  = 1'b0;
        btn_lap = 1'b0;
        wait_neg(15);

        // 5. Up alone restores u=1, then up+clr together
        btn_up = 1'b1;
        wait_neg(8);
        chk("up_restore", u, 1'b1);
        btn_up = 1'b0;
        wait_neg(15);
        btn_up  = 1'b1;
        btn_clr = 1'b1;
        wait_neg(8);
        chk_all("up_clr", 1'b0, 1'b1, 1'b0, 1'b0);
        wait_neg(1);
        chk_all("up_clr_done", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_up  = 1'b0;
        btn_clr = 1'b0;
        wait_neg(15);

        // 6. Reset while lap is mid-debounce, button held throughout
        btn_lap = 1'b1;
        wait_neg(4);
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_neg(1);
            chk_all("mid_reset", 1'b0, 1'b0, 1'b1, 1'b0);
        end
        reset_n = 1'b1;
        wait_neg(7);
        chk("lap_before", p, 1'b0);
        wait_neg(1);
        chk_all("lap_after", 1'b0, 1'b0, 1'b1, 1'b1);
        btn_lap = 1'b0;
        wait_neg(15);
        chk("lap_settled", p, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
